// File: rtl/digit_scanner_pkg.sv
// Shared display-bank definitions: digit width, nibble type and index-width helper.
package disp_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] nibble_t;

    // Width of a digit index for n digits; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_scanner_scan_timer.sv
// scan_timer: slot prescaler and digit index for the display scan.
//   clk, reset : system clock, synchronous active-high reset
//   idx        : currently selected digit, 0..NDIGITS-1
//   tick       : last cycle of the current slot
//   wrap       : last cycle of the last slot of the frame
module scan_timer
    import disp_pkg::*;
#(
    parameter  int unsigned NDIGITS = 8,
    parameter  int unsigned DIV     = 100000,
    localparam int unsigned IDX_W   = idx_width(NDIGITS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] idx,
    output logic             tick,
    output logic             wrap
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             last_digit;

    // Next-state logic for prescaler and digit index.
    always_comb begin
        cnt_nxt    = cnt + CNT_W'(1);
        idx_nxt    = idx;
        tick       = (cnt == CNT_W'(DIV - 1));
        last_digit = (idx == IDX_W'(NDIGITS - 1));
        wrap       = tick && last_digit;
        if (tick) begin
            cnt_nxt = '0;
            idx_nxt = last_digit ? '0 : idx + IDX_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/digit_scanner.sv
// digit_scanner: time-multiplexed common-anode 7-segment scan driver.
// A word accepted on valid_i/ready_o waits in a pending register and is
// moved to the displayed word only at a frame boundary, so a frame never
// mixes two words.
//   clk, reset  : system clock, synchronous active-high reset
//   data_i      : NDIGITS packed 4-bit codes, digit 0 in the low nibble
//   valid_i     : data_i valid
//   ready_o     : pending register empty
//   blank_en_i  : leading-zero blanking enable (combinational)
//   an_o        : active-low anode select, at most one bit low
//   nibble_o    : code of the selected digit (0 when blanked)
//   blank_o     : selected digit is blanked
//   idx_o       : index of the selected digit
//   frame_o     : pulse in the first cycle of slot 0
module digit_scanner
    import disp_pkg::*;
#(
    parameter  int unsigned NDIGITS = 8,
    parameter  int unsigned DIV     = 100000,
    localparam int unsigned IDX_W   = idx_width(NDIGITS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DIGIT_W*NDIGITS-1:0]   data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         blank_en_i,
    output logic [NDIGITS-1:0]           an_o,
    output nibble_t                      nibble_o,
    output logic                         blank_o,
    output logic [IDX_W-1:0]             idx_o,
    output logic                         frame_o
);

    localparam int unsigned WORD_W = DIGIT_W * NDIGITS;

    logic [IDX_W-1:0]  idx;
    logic              tick;
    logic              wrap;

    logic [WORD_W-1:0] disp;
    logic [WORD_W-1:0] disp_nxt;
    logic [WORD_W-1:0] pend;
    logic [WORD_W-1:0] pend_nxt;
    logic              pend_full;
    logic              pend_full_nxt;
    logic              accept;

    logic [NDIGITS-1:0] zero_from;
    nibble_t            cur_digit;
    logic               cur_zero_from;
    logic               blanked;
    logic               zero_acc;

    scan_timer #(
        .NDIGITS (NDIGITS),
        .DIV     (DIV)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .idx   (idx),
        .tick  (tick),
        .wrap  (wrap)
    );

    // A frame can only end at the end of a slot.
    always_comb begin
        if (!reset) begin
            assert (!wrap || tick);
        end
    end

    // Handshake and frame-boundary word transfer. An accept in the wrap
    // cycle lands in pend only; it is shown one frame later.
    always_comb begin
        disp_nxt      = disp;
        pend_nxt      = pend;
        pend_full_nxt = pend_full;
        accept        = valid_i && !pend_full;
        if (wrap && pend_full) begin
            disp_nxt      = pend;
            pend_full_nxt = 1'b0;
        end
        if (accept) begin
            pend_nxt      = data_i;
            pend_full_nxt = 1'b1;
        end
    end

    // Word registers and frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            frame_o   <= 1'b0;
        end else begin
            disp      <= disp_nxt;
            pend      <= pend_nxt;
            pend_full <= pend_full_nxt;
            frame_o   <= wrap;
        end
    end

    // zero_from[i]: digits i..NDIGITS-1 of the displayed word are all zero.
    always_comb begin
        zero_from = '0;
        zero_acc  = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_acc     = zero_acc && (disp[DIGIT_W*i +: DIGIT_W] == '0);
            zero_from[i] = zero_acc;
        end
    end

    // Select the current digit; digit 0 is never blanked.
    always_comb begin
        cur_digit     = '0;
        cur_zero_from = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit     = disp[DIGIT_W*i +: DIGIT_W];
                cur_zero_from = zero_from[i];
            end
        end
        blanked  = blank_en_i && (idx != '0) && cur_zero_from;
        nibble_o = blanked ? nibble_t'(0) : cur_digit;
        blank_o  = blanked;
        an_o     = blanked ? '1 : ~(NDIGITS'(1) << idx);
        idx_o    = idx;
        ready_o  = !pend_full;
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboarded bench for digit_scanner: a 4-digit/DIV=4 instance and a
// 1-digit/DIV=2 instance, each against a cycle-count reference model.
module tb_digit_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-digit instance
    logic        rst0, valid0, ben0, ready0, blank0, frame0;
    logic [15:0] data0;
    logic [3:0]  an0, nib0;
    logic [1:0]  idx0;

    // 1-digit instance
    logic        rst1, valid1, ben1, ready1, blank1, frame1;
    logic [3:0]  data1, nib1;
    logic [0:0]  an1, idx1;

    digit_scanner #(.NDIGITS(4), .DIV(4)) dut0 (
        .clk(clk), .reset(rst0), .data_i(data0), .valid_i(valid0), .ready_o(ready0),
        .blank_en_i(ben0), .an_o(an0), .nibble_o(nib0), .blank_o(blank0),
        .idx_o(idx0), .frame_o(frame0)
    );

    digit_scanner #(.NDIGITS(1), .DIV(2)) dut1 (
        .clk(clk), .reset(rst1), .data_i(data1), .valid_i(valid1), .ready_o(ready1),
        .blank_en_i(ben1), .an_o(an1), .nibble_o(nib1), .blank_o(blank1),
        .idx_o(idx1), .frame_o(frame1)
    );

    // Model state: cycles since reset release, shown word, pending word.
    typedef struct {
        int          t;
        logic [63:0] disp;
        logic [63:0] pend;
        bit          full;
    } mstate_t;

    typedef struct {
        bit          ready;
        logic [15:0] an;
        logic [3:0]  nib;
        bit          blank;
        int          idx;
        bit          frame;
    } exp_t;

    exp_t    q0[$];
    exp_t    q1[$];
    mstate_t s0, s1;
    int      checks = 0;
    int      errors = 0;
    bit      done0 = 0;
    bit      done1 = 0;

    function automatic mstate_t model_reset();
        mstate_t s;
        s.t = 0; s.disp = '0; s.pend = '0; s.full = 0;
        return s;
    endfunction

    // Expected outputs in the current cycle, from slot arithmetic on t.
    function automatic exp_t model_out(mstate_t s, int n, int d, bit ben);
        exp_t        e;
        int          slot;
        logic [63:0] upper;
        bit          blk;
        slot    = (s.t / d) % n;
        upper   = s.disp >> (4 * slot);
        blk     = ben && (slot > 0) && (upper == 64'h0);
        e.ready = !s.full;
        e.idx   = slot;
        e.frame = (s.t > 0) && ((s.t % (n * d)) == 0);
        e.blank = blk;
        e.nib   = blk ? 4'h0 : 4'(upper & 64'hF);
        e.an    = blk ? 16'hFFFF : ~(16'(1) << slot);
        return e;
    endfunction

    // Advance one cycle: frame-end transfer first, then the accept.
    function automatic mstate_t model_next(mstate_t s, int n, int d, bit v, logic [63:0] data);
        mstate_t r;
        bit      at_end;
        bit      rdy;
        r      = s;
        at_end = (s.t % (n * d)) == (n * d - 1);
        rdy    = !s.full;
        if (at_end && s.full) begin
            r.disp = s.pend;
            r.full = 0;
        end
        if (v && rdy) begin
            r.pend = data;
            r.full = 1;
        end
        r.t = s.t + 1;
        return r;
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endfunction

    // ---------------- stimulus, 4-digit instance ----------------
    task automatic step0(bit v, logic [15:0] d, bit ben);
        valid0 = v; data0 = d; ben0 = ben;
        q0.push_back(model_out(s0, 4, 4, ben));
        s0 = model_next(s0, 4, 4, v, {48'h0, d});
        @(posedge clk); #1;
    endtask

    task automatic reset0();
        rst0 = 1; valid0 = 0; data0 = '0;
        repeat (3) begin @(posedge clk); #1; end
        rst0 = 0;
        s0 = model_reset();
    endtask

    initial begin
        bit          acc;
        bit          ben;
        int          k;
        logic [15:0] d;
        rst0 = 1; valid0 = 0; data0 = '0; ben0 = 0;
        reset0();
        // one word shown through several frames
        step0(0, 16'h0, 0);
        step0(1, 16'h1234, 0);
        repeat (40) step0(0, 16'h0, 0);
        // pending full: upstream holds B until accepted
        step0(1, 16'hAAAA, 0);
        k = 0;
        do begin
            acc = !s0.full;
            step0(1, 16'hBBBB, 0);
            k++;
        end while (!acc && k < 100);
        repeat (40) step0(0, 16'h0, 0);
        // reset in the middle of a slot, with a word pending
        repeat (5) step0(0, 16'h0, 0);
        step0(1, 16'h9876, 0);
        repeat (2) step0(0, 16'h0, 0);
        reset0();
        // accept exactly in the frame-end cycle with pend empty
        repeat (20) step0(0, 16'h0, 0);
        k = 0;
        while (!(((s0.t % 16) == 15) && !s0.full) && k < 200) begin
            step0(0, 16'h0, 0);
            k++;
        end
        step0(1, 16'h5555, 0);
        repeat (40) step0(0, 16'h0, 0);
        // leading-zero blanking
        step0(1, 16'h0050, 1);
        repeat (36) step0(0, 16'h0, 1);
        step0(1, 16'h0000, 1);
        repeat (36) step0(0, 16'h0, 1);
        repeat (20) step0(0, 16'h0, 0);
        // random traffic, with leading-zero heavy words
        ben = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) ben = ~ben;
            d = 16'($urandom);
            d = d >> (4 * $urandom_range(0, 4));
            if (i == 200) reset0();
            step0($urandom_range(0, 2) == 0, d, ben);
        end
        valid0 = 0;
        done0 = 1;
    end

    // ---------------- stimulus, 1-digit instance ----------------
    task automatic step1(bit v, logic [3:0] d, bit ben);
        valid1 = v; data1 = d; ben1 = ben;
        q1.push_back(model_out(s1, 1, 2, ben));
        s1 = model_next(s1, 1, 2, v, {60'h0, d});
        @(posedge clk); #1;
    endtask

    initial begin
        rst1 = 1; valid1 = 0; data1 = '0; ben1 = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst1 = 0;
        s1 = model_reset();
        step1(1, 4'h7, 1);
        repeat (4) step1(0, 4'h0, 1);
        step1(1, 4'h0, 1);
        repeat (4) step1(0, 4'h0, 1);
        for (int i = 0; i < 80; i++)
            step1($urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 1) == 1);
        valid1 = 0;
        done1 = 1;
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("ready0", 64'(ready0), 64'(e.ready));
            chk("an0",    64'(an0),    64'(e.an[3:0]));
            chk("nib0",   64'(nib0),   64'(e.nib));
            chk("blank0", 64'(blank0), 64'(e.blank));
            chk("idx0",   64'(idx0),   64'(e.idx));
            chk("frame0", 64'(frame0), 64'(e.frame));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("ready1", 64'(ready1), 64'(e.ready));
            chk("an1",    64'(an1),    64'(e.an[0:0]));
            chk("nib1",   64'(nib1),   64'(e.nib));
            chk("blank1", 64'(blank1), 64'(e.blank));
            chk("idx1",   64'(idx1),   64'(e.idx));
            chk("frame1", 64'(frame1), 64'(e.frame));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=timeout expected=completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait (done0 && done1);
        @(negedge clk); #1;
        chk("drain0", 64'(q0.size()), 64'h0);
        chk("drain1", 64'(q1.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
